video_pll_lock_sequencer: RTL
=============================

// Module: video_pll_lock_sequencer
// PURPOSE
//  Sequences reset/lock bring-up of the video-clock PLL (50 MHz ref -> 25/25/33 MHz outputs).
//  Pulses PLL reset, waits for a debounced lock, then releases the video-domain reset.
//  Restarts the PLL on lock loss or lock timeout; latches a fault after MAX_RETRY failed attempts.
//  Runs on the PLL reference clock; sits between board reset and the PLL wrapper / video pipeline.
// PARAMETERS
//  RST_CYCLES    16      cycles pll_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT  500000  max cycles in WAIT_LOCK before retry (10 ms @ 50 MHz)
//  LOCK_STABLE   1024    consecutive synced-lock cycles required before RUN
//  MAX_RETRY     3       failed attempts (timeouts) before FAULT (1..15)
//  CNT_W         24      width of shared cycle counter; must hold max(RST_CYCLES,LOCK_TIMEOUT,LOCK_STABLE)
// PORTS
//  clk            in   1  reference clock (same net as PLL refclk)
//  reset_n        in   1  async active-low reset
//  restart        in   1  1-cycle pulse: restart sequence from PLL_RST, clears fault/retries
//  pll_locked     in   1  PLL locked, asynchronous to clk
//  pll_rst        out  1  to PLL rst, active high
//  video_reset_n  out  1  video-domain reset release, active low (consumer resynchronises)
//  ready          out  1  1 only in RUN
//  fault          out  1  1 only in FAULT
//  lock_lost      out  1  1-cycle pulse on lock loss while in RUN
//  retry_cnt      out  4  timeout retries in current bring-up
//  state_dbg      out  3  encoded state: PLL_RST=0 WAIT_LOCK=1 STABLE=2 RUN=3 FAULT=4
// BEHAVIOUR
//  Reset (reset_n=0, async): state=PLL_RST, cnt=0, pll_rst=1, video_reset_n=0, ready=0, fault=0,
//   lock_lost=0, retry_cnt=0, sync flops=0. All outputs registered.
//  pll_locked passes a 2-flop synchroniser -> lock_s (2-cycle latency); FSM uses lock_s only.
//  PLL_RST: pll_rst=1; cnt++; on cnt==RST_CYCLES-1 -> WAIT_LOCK, cnt=0.
//  WAIT_LOCK: pll_rst=0; lock_s=1 -> STABLE, cnt=0; else cnt==LOCK_TIMEOUT-1 -> timeout:
//   retry_cnt+1 == MAX_RETRY -> FAULT, else -> PLL_RST; retry_cnt++ either way; cnt=0.
//  STABLE: lock_s=0 -> WAIT_LOCK, cnt=0 (timeout window restarts); cnt==LOCK_STABLE-1 -> RUN.
//  RUN: video_reset_n=1, ready=1; retry_cnt cleared on entry. lock_s=0 -> PLL_RST, cnt=0,
//   lock_lost=1 for one cycle, video_reset_n=0 and ready=0 in the same registered update.
//  FAULT: pll_rst=1 (PLL parked), video_reset_n=0, fault=1; exits only on restart or reset_n.
//  restart (any state, highest priority): -> PLL_RST, cnt=0, retry_cnt=0, fault=0 next cycle;
//   in RUN also drops video_reset_n/ready next cycle; lock_lost NOT pulsed.
//  video_reset_n=1 iff state==RUN; pll_rst=1 iff state in {PLL_RST, FAULT}.
//  Simultaneous restart and lock loss/timeout: restart wins; retry_cnt=0.
//  Counter never wraps: reset to 0 on every state change; retry_cnt saturates at MAX_RETRY.
//  Glitch on pll_locked shorter than 1 clk may be missed; any lock_s=0 sample in STABLE/RUN acts.
//  reset_n asserted mid-sequence: immediate return to reset values, regardless of state.
// TESTING (RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRY=3)
//  1 Bring-up: release reset_n, pll_locked=1 from cycle 10 -> pll_rst high cycles 0-3, RUN and
//    video_reset_n=1 exactly 2 (sync) + 8 cycles after first lock sample, retry_cnt=0.
//  2 Lock loss: in RUN drop pll_locked -> lock_lost pulse 1 cycle, video_reset_n=0, pll_rst=1 for
//    4 cycles, then normal re-lock to RUN when pll_locked returns.
//  3 Timeouts: pll_locked=0 forever -> three 20-cycle WAIT_LOCK windows, retry_cnt 1,2,3,
//    FAULT with fault=1, pll_rst=1; remains in FAULT for 1000 cycles.
//  4 Debounce: in STABLE toggle pll_locked low for 3 cycles at stable count 5 -> back to
//    WAIT_LOCK, no RUN until 8 uninterrupted lock cycles.
//  5 Restart: from FAULT pulse restart -> fault=0, retry_cnt=0, PLL_RST next cycle; restart and
//    lock loss in same RUN cycle -> lock_lost stays 0.
//  6 Async reset mid-STABLE: assert reset_n low -> all outputs at reset values without a clk edge.

Source files
------------

// File: rtl/video_pll_lock_sequencer.sv
// Video PLL bring-up sequencer: pulse PLL reset, debounce lock, release video reset, retry or fault.
// Latency: pll_locked -> lock_s takes 2 cycles; each FSM decision is visible 1 cycle after lock_s.
// Backpressure: none; restart pulse has highest priority, reset_n returns everything at once.
module video_pll_lock_sequencer #(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_TIMEOUT = 500000,
   parameter int LOCK_STABLE  = 1024,
   parameter int MAX_RETRY    = 3,
   parameter int CNT_W        = 24
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       restart,
   input  logic       pll_locked,
   output logic       pll_rst,
   output logic       video_reset_n,
   output logic       ready,
   output logic       fault,
   output logic       lock_lost,
   output logic [3:0] retry_cnt,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   // Terminal counts of the shared counter, one per timed state.
   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
   localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRY);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             lock_meta;
   logic             lock_s;

   assign state_dbg = state;

   // Two-flop synchroniser: pll_locked comes from the PLL with no timing relation to clk.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= pll_locked;
         lock_s    <= lock_meta;
      end
   end

   // Bring-up FSM; every output is registered and updated together with the state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_PLL_RST;
         cnt           <= '0;
         pll_rst       <= 1'b1;
         video_reset_n <= 1'b0;
         ready         <= 1'b0;
         fault         <= 1'b0;
         lock_lost     <= 1'b0;
         retry_cnt     <= 4'd0;
      end else begin
         lock_lost <= 1'b0;
         if (restart) begin
            // Restart overrides any simultaneous lock loss or timeout and forgets history.
            state         <= S_PLL_RST;
            cnt           <= '0;
            retry_cnt     <= 4'd0;
            pll_rst       <= 1'b1;
            video_reset_n <= 1'b0;
            ready         <= 1'b0;
            fault         <= 1'b0;
         end else begin
            case (state)
               S_PLL_RST: begin
                  if (cnt == RST_LAST) begin
                     state   <= S_WAIT_LOCK;
                     cnt     <= '0;
                     pll_rst <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end

               S_WAIT_LOCK: begin
                  if (lock_s) begin
                     state <= S_STABLE;
                     cnt   <= '0;
                  end else if (cnt == TIMEOUT_LAST) begin
                     cnt     <= '0;
                     pll_rst <= 1'b1;
                     if (retry_cnt != RETRY_MAX) begin
                        retry_cnt <= retry_cnt + 4'd1;
                     end
                     if (retry_cnt + 4'd1 == RETRY_MAX) begin
                        state <= S_FAULT;
                        fault <= 1'b1;
                     end else begin
                        state <= S_PLL_RST;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end

               S_STABLE: begin
                  // A single low sample restarts the lock wait with a fresh timeout window.
                  if (!lock_s) begin
                     state <= S_WAIT_LOCK;
                     cnt   <= '0;
                  end else if (cnt == STABLE_LAST) begin
                     state         <= S_RUN;
                     cnt           <= '0;
                     retry_cnt     <= 4'd0;
                     video_reset_n <= 1'b1;
                     ready         <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end

               S_RUN: begin
                  if (!lock_s) begin
                     state         <= S_PLL_RST;
                     cnt           <= '0;
                     pll_rst       <= 1'b1;
                     video_reset_n <= 1'b0;
                     ready         <= 1'b0;
                     lock_lost     <= 1'b1;
                  end
               end

               S_FAULT: begin
                  // PLL stays parked in reset until restart or reset_n.
                  cnt <= '0;
               end

               default: begin
                  state         <= S_PLL_RST;
                  cnt           <= '0;
                  pll_rst       <= 1'b1;
                  video_reset_n <= 1'b0;
                  ready         <= 1'b0;
                  fault         <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
